// File: rtl/frame_source_arbiter.sv
// Frame-granular round-robin arbiter sharing one grayscale path between two FWFT RGB source FIFOs.
// Pixels pass through combinationally while a frame is granted; grants change only between frames.
module frame_source_arbiter #(
  parameter  int WIDTH        = 720,
  parameter  int HEIGHT       = 540,
  localparam int FRAME_PIXELS = WIDTH * HEIGHT,
  localparam int CNT_W        = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic [1:0]  in_rd_en,
  input  logic [1:0]  in_empty,
  input  logic [47:0] in_dout,
  output logic        out_wr_en,
  input  logic        out_full,
  output logic [23:0] out_din,
  output logic        grant,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_PIXEL = CNT_W'(FRAME_PIXELS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             xfer;

  assign xfer = (state_q == XFER) && !in_empty[grant_q] && !out_full;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    busy_d        = busy_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        // The source that did not win last time gets first refusal.
        if (enable && (in_empty != 2'b11)) begin
          grant_d = in_empty[~last_grant_q] ? last_grant_q : ~last_grant_q;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        if (xfer) begin
          if (cnt_q == LAST_PIXEL) begin
            cnt_d         = '0;
            busy_d        = 1'b0;
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            state_d       = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        last_grant_d = grant_q;
        cnt_d        = '0;
        state_d      = IDLE;
      end
      default: begin
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_grant_q  <= 1'b1;
      grant_q       <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign in_rd_en    = {xfer & grant_q, xfer & ~grant_q};
  assign out_wr_en   = xfer;
  assign out_din     = (state_q == XFER) ? (grant_q ? in_dout[47:24] : in_dout[23:0]) : 24'h0;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_source_arbiter.sv
// Self-checking bench: queue-backed FWFT sources and a frame-level reference model checked every cycle.
module tb_frame_source_arbiter;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 2;
  localparam int FP     = WIDTH * HEIGHT;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  in_rd_en;
  logic [1:0]  in_empty = 2'b11;
  logic [47:0] in_dout = '0;
  logic        out_wr_en;
  logic        out_full = 1'b0;
  logic [23:0] out_din;
  logic        grant;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;

  frame_source_arbiter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .in_rd_en(in_rd_en), .in_empty(in_empty), .in_dout(in_dout),
    .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din),
    .grant(grant), .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  logic [23:0] q0[$];
  logic [23:0] q1[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: 0 = waiting for a grant, 1 = frame in flight, 2 = completion cycle.
  int          m_phase = 0;
  int          m_left  = 0;
  bit          m_src   = 1'b0;
  bit          m_last  = 1'b1;
  bit          m_grant = 1'b0;
  logic [15:0] m_count = 16'd0;

  task automatic checkOutput(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst_n, input bit en, input bit full);
    logic [47:0] din;
    logic [23:0] e_din;
    logic [1:0]  e_rd;
    bit          avail;
    @(negedge clock);
    reset    = rst_n;
    enable   = en;
    out_full = full;
    din[23:0]  = (q0.size() != 0) ? q0[0] : 24'($urandom);
    din[47:24] = (q1.size() != 0) ? q1[0] : 24'($urandom);
    in_dout  = din;
    in_empty = {q1.size() == 0, q0.size() == 0};
    #1;
    avail = (m_phase == 1) && (m_src ? (q1.size() != 0) : (q0.size() != 0)) && !full;
    e_din = (m_phase == 1) ? (m_src ? din[47:24] : din[23:0]) : 24'h0;
    e_rd  = avail ? (m_src ? 2'b10 : 2'b01) : 2'b00;
    checkOutput("busy", 48'(busy), 48'(m_phase == 1));
    checkOutput("grant", 48'(grant), 48'(m_grant));
    checkOutput("frame_done", 48'(frame_done), 48'(m_phase == 2));
    checkOutput("out_wr_en", 48'(out_wr_en), 48'(avail));
    checkOutput("in_rd_en", 48'(in_rd_en), 48'(e_rd));
    checkOutput("out_din", 48'(out_din), 48'(e_din));
    if (m_phase != 2) checkOutput("frame_count", 48'(frame_count), 48'(m_count));
    if (in_rd_en[0] && q0.size() != 0) void'(q0.pop_front());
    if (in_rd_en[1] && q1.size() != 0) void'(q1.pop_front());
    if (!rst_n) begin
      m_phase = 0; m_left = 0; m_last = 1'b1; m_grant = 1'b0; m_count = 16'd0;
    end else begin
      case (m_phase)
        0: if (en && (in_empty != 2'b11)) begin
             m_src   = !in_empty[!m_last] ? !m_last : m_last;
             m_grant = m_src;
             m_left  = FP;
             m_phase = 1;
           end
        1: if (avail) begin
             m_left--;
             if (m_left == 0) m_phase = 2;
           end
        default: begin
          m_count = m_count + 16'd1;
          m_last  = m_src;
          m_phase = 0;
        end
      endcase
    end
  endtask

  task automatic runCycles(input int n, input bit en, input int mode);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b1, en, (mode == 1) ? i[0] : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("reset_count", 48'(frame_count), 48'd0);

    for (int i = 1; i <= 8; i++) q0.push_back(24'(i));
    runCycles(14, 1'b1, 0);
    checkOutput("single_count", 48'(frame_count), 48'd1);

    for (int i = 0; i < 16; i++) begin
      q0.push_back(24'h000100 | 24'(i));
      q1.push_back(24'hAA0000 | 24'(i));
    end
    runCycles(50, 1'b1, 0);
    checkOutput("rr_count", 48'(frame_count), 48'd5);

    for (int i = 0; i < 8; i++) q0.push_back(24'h003000 | 24'(i));
    runCycles(25, 1'b1, 1);
    checkOutput("bp_count", 48'(frame_count), 48'd6);

    for (int i = 0; i < 5; i++) q0.push_back(24'h004000 | 24'(i));
    runCycles(3, 1'b1, 0);
    for (int i = 0; i < 8; i++) q1.push_back(24'hAA4000 | 24'(i));
    runCycles(20, 1'b1, 0);
    checkOutput("underflow_busy", 48'(busy), 48'd1);
    checkOutput("underflow_grant", 48'(grant), 48'd0);
    for (int i = 5; i < 8; i++) q0.push_back(24'h004000 | 24'(i));
    runCycles(30, 1'b1, 0);
    checkOutput("underflow_count", 48'(frame_count), 48'd8);

    for (int i = 0; i < 8; i++) q0.push_back(24'h005000 | 24'(i));
    runCycles(4, 1'b1, 0);
    for (int i = 0; i < 8; i++) q1.push_back(24'hAA5000 | 24'(i));
    runCycles(20, 1'b0, 0);
    checkOutput("enable_count", 48'(frame_count), 48'd9);
    checkOutput("enable_idle", 48'(busy), 48'd0);

    runCycles(5, 1'b1, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    q0.delete();
    q1.delete();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("reset_busy", 48'(busy), 48'd0);
    checkOutput("reset_done", 48'(frame_done), 48'd0);
    for (int i = 0; i < 8; i++) begin
      q0.push_back(24'h006000 | 24'(i));
      q1.push_back(24'hAA6000 | 24'(i));
    end
    runCycles(2, 1'b1, 0);
    checkOutput("post_reset_grant", 48'(grant), 48'd0);
    runCycles(24, 1'b1, 0);
    checkOutput("post_reset_count", 48'(frame_count), 48'd2);

    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) != 0) q0.push_back(24'($urandom));
      if ($urandom_range(0, 2) == 0) q1.push_back(24'($urandom));
      applyStimulus(1'b1, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)));
    end

    applyStimulus(1'b0, 1'b0, 1'b0);
    q0.delete();
    q1.delete();
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clock);
    force dut.frame_count_q = 16'hFFFE;
    m_count = 16'hFFFE;
    applyStimulus(1'b1, 1'b0, 1'b0);
    release dut.frame_count_q;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("preload_count", 48'(frame_count), 48'hFFFE);
    for (int i = 0; i < 16; i++) q0.push_back(24'h007000 | 24'(i));
    runCycles(12, 1'b1, 0);
    checkOutput("count_ffff", 48'(frame_count), 48'hFFFF);
    runCycles(12, 1'b1, 0);
    checkOutput("count_wrap", 48'(frame_count), 48'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
